// File: rtl/mac_rx_fifo_ctrl.sv
// Frame-aware receive FIFO controller driving an external two-port SRAM.
// Only committed, error-free frames become visible on the read side; bad frames roll back.
module mac_rx_fifo_ctrl #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          iRst,
  input  logic          iWrVld,
  input  logic [DW-1:0] iWrData,
  input  logic          iWrEop,
  input  logic          iWrErr,
  output logic          oMemWr,
  output logic [AW-1:0] oMemWrAddr,
  output logic [DW:0]   oMemWrData,
  output logic          oMemRd,
  output logic [AW-1:0] oMemRdAddr,
  input  logic [DW:0]   iMemRdData,
  output logic          oRdVld,
  output logic [DW-1:0] oRdData,
  output logic          oRdEop,
  input  logic          iRdRdy,
  output logic [AW:0]   oFrames,
  output logic [15:0]   oDropCnt
);

  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, used, frames;
  logic        full, dropping, in_flight;
  logic        good_eop, bad_eop, pop, issue;
  logic [1:0]  buf_cnt, buf_cnt_nxt;
  logic [DW:0] buf0, buf1, buf0_nxt, buf1_nxt;
  logic [2:0]  occ;
  logic [15:0] drop_cnt;

  // Read words free their space when issued, so fullness is measured against rd_ptr.
  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == DEPTH);
  assign good_eop = iWrVld & iWrEop & ~iWrErr & ~dropping & ~full & ~iRst;
  assign bad_eop  = iWrVld & iWrEop & ~good_eop & ~iRst;

  // A bad EOP word is never written; the frame is rolled back instead.
  assign oMemWr     = iWrVld & ~full & ~dropping & ~(iWrEop & iWrErr) & ~iRst;
  assign oMemWrAddr = wr_ptr[AW-1:0];
  assign oMemWrData = oMemWr ? {iWrEop, iWrData} : {(DW+1){1'b0}};

  assign oRdVld  = (buf_cnt != 2'd0);
  assign oRdData = buf0[DW-1:0];
  assign oRdEop  = buf0[DW];
  assign pop     = oRdVld & iRdRdy;

  // Counting the pop lets a new read issue every cycle while the head drains.
  assign occ        = {1'b0, buf_cnt} + {2'b00, in_flight} - {2'b00, pop};
  assign issue      = ~iRst & (rd_ptr != commit_ptr) & (occ < 3'd2);
  assign oMemRd     = issue;
  assign oMemRdAddr = rd_ptr[AW-1:0];
  assign oFrames    = frames;
  assign oDropCnt   = drop_cnt;

  // Output buffer next state: head shift on pop, returning SRAM word fills the first free slot.
  always_comb begin
    buf0_nxt    = buf0;
    buf1_nxt    = buf1;
    buf_cnt_nxt = buf_cnt;
    case ({pop, in_flight})
      2'b10: begin
        buf0_nxt    = buf1;
        buf_cnt_nxt = buf_cnt - 2'd1;
      end
      2'b01: begin
        if (buf_cnt == 2'd0) begin
          buf0_nxt = iMemRdData;
        end else begin
          buf1_nxt = iMemRdData;
        end
        buf_cnt_nxt = buf_cnt + 2'd1;
      end
      2'b11: begin
        if (buf_cnt == 2'd1) begin
          buf0_nxt = iMemRdData;
        end else begin
          buf0_nxt = buf1;
          buf1_nxt = iMemRdData;
        end
      end
      default: begin
        buf_cnt_nxt = buf_cnt;
      end
    endcase
  end

  // Pointer, drop, frame-count and buffer state.
  always_ff @(posedge clk) begin
    if (iRst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      dropping   <= 1'b0;
      in_flight  <= 1'b0;
      buf_cnt    <= 2'd0;
      buf0       <= '0;
      buf1       <= '0;
      frames     <= '0;
      drop_cnt   <= 16'd0;
    end else begin
      if (bad_eop) begin
        wr_ptr <= commit_ptr;
      end else if (oMemWr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (good_eop) begin
        commit_ptr <= wr_ptr + PTR_ONE;
      end
      if (iWrVld) begin
        if (iWrEop) begin
          dropping <= 1'b0;
        end else if (full) begin
          dropping <= 1'b1;
        end
      end
      if (bad_eop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      in_flight <= issue;
      buf0      <= buf0_nxt;
      buf1      <= buf1_nxt;
      buf_cnt   <= buf_cnt_nxt;
      case ({good_eop, pop & oRdEop})
        2'b10:   frames <= frames + PTR_ONE;
        2'b01:   frames <= frames - PTR_ONE;
        default: frames <= frames;
      endcase
    end
  end

endmodule
